ps2_keyboard: RTL

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines, frames
// 11-bit words, and emits each valid scan code with a one-cycle strobe.
module ps2_keyboard #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] kb_data,
  output logic       kb_hit,
  output logic       kb_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic           r_filt_clk, r_filt_prev;
  logic [FCW-1:0] r_filt_cnt;
  state_t         r_state;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic [TCW-1:0] r_to_cnt;
  logic [7:0]     r_kb_data;
  logic           r_kb_hit, r_kb_err;
  logic           w_sample;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline stages stay one cycle apart.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_dat;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt_clk;
      // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
    end
  end

  assign w_sample = r_filt_prev & ~r_filt_clk;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_kb_data <= 8'h00;
      r_kb_hit  <= 1'b0;
      r_kb_err  <= 1'b0;
    end else begin
      r_kb_hit <= 1'b0;
      r_kb_err <= 1'b0;

      if (w_sample || r_state == IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TCW'(TIMEOUT)) begin
        r_to_cnt <= r_to_cnt + TCW'(1);
      end

      if (w_sample) begin
        case (r_state)
          IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else begin
              r_kb_err <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= STOP;
          end
          STOP: begin
            if (r_dat_s2 && (^{r_shift, r_parity})) begin
              r_kb_data <= r_shift;
              r_kb_hit  <= 1'b1;
            end else begin
              r_kb_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE && r_to_cnt == TCW'(TIMEOUT)) begin
        // Keyboard went silent mid-frame: drop the partial frame.
        r_state  <= IDLE;
        r_kb_err <= 1'b1;
      end
    end
  end

  assign kb_data = r_kb_data;
  assign kb_hit  = r_kb_hit;
  assign kb_err  = r_kb_err;

endmodule
